// File: rtl/spm_pkg.sv
// Shared types and constants for the RISC_SPM program-load path.
package spm_pkg;

    localparam int         MEM_DEPTH = 256;
    localparam logic [7:0] SOF       = 8'hA5;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        GET_ADDR,
        GET_LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/spm_boot_loader.sv
// Clears RISC_SPM program memory, loads one checksummed frame from a byte stream, then releases cpu_rst_n.
// Writes appear 1 cycle after the data handshake; in_ready is registered from state only (low in CLEAR/DONE).
module spm_boot_loader
    import spm_pkg::*;
#(
    parameter int               ADDR_W         = $clog2(MEM_DEPTH),
    parameter int               DATA_W         = 8,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] SOF_BYTE      = DATA_W'(SOF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;

    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            CLEAR: begin
                // addr_q doubles as the fill pointer and wraps back to 0 for the first frame
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = '0;
                addr_d      = addr_q + ADDR_W'(1);
                if (addr_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE, ERROR: begin
                if (xfer && in_data == SOF_BYTE) begin
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (xfer) begin
                    addr_d  = ADDR_W'(in_data);
                    sum_d   = in_data;
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (xfer) begin
                    // a zero length byte means a full memory image
                    cnt_d   = (in_data == '0) ? (ADDR_W+1)'(2**ADDR_W) : (ADDR_W+1)'(in_data);
                    sum_d   = sum_q + in_data;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - (ADDR_W+1)'(1);
                    sum_d       = sum_q + in_data;
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (in_data == sum_q) ? DONE : ERROR;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // status outputs are registered copies of what the next state implies
        in_ready_d  = !(state_d inside {CLEAR, DONE});
        busy_d      = state_d inside {CLEAR, GET_ADDR, GET_LEN, DATA, CHECK};
        done_d      = (state_d == DONE);
        cpu_rst_n_d = (state_d == DONE);
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spm_boot_loader.sv
// Bench for spm_boot_loader: hand sequences, a frame table and random frames checked against a memory-image model.
module tb_spm_boot_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst_n;
    logic       busy;
    logic       done;
    logic       err;

    spm_boot_loader #(
        .ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1'b1), .SOF_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] seed;
        bit         corrupt;
        int         gap;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    int         total;
    int         bad;
    wr_t        wq[$];
    logic [7:0] dmem[256];
    logic [7:0] rmem[256];
    logic [7:0] nom_img[256];
    logic [7:0] fdata[$];
    vec_t       tbl[5];

    // memory as the core would see it, built from observed write-port activity
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back('{mem_addr, mem_wdata});
            dmem[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) n++;
        return n;
    endfunction

    // called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("send_timeout", 32'(n), 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic reset_and_clear();
        int n = 0;
        int bc = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reset_values", {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        wq.delete();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        while (in_ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("clear_in_time", 32'(n < 600), 1);
        chk("post_clear_flags", {in_ready, cpu_rst_n, busy, done}, 4'b1000);
        @(negedge clk);
        if (wq.size() != 256) bc++;
        for (int i = 0; i < wq.size(); i++) begin
            logic [7:0] ea = 8'(i);
            if (wq[i].a !== ea || wq[i].d !== 8'h00) bc++;
        end
        chk("clear_writes", 32'(bc), 0);
    endtask

    task automatic load_nominal();
        fdata = '{8'h00, 8'h50, 8'h03, 8'h40, 8'h80};
    endtask

    // sends one frame from fdata, updating the reference image and checking the outcome
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] len, input bit corrupt, input int gap);
        int         n;
        int         mm = 0;
        logic [7:0] cs;
        wr_t        exp_w[$];
        n  = (len == 8'h00) ? 256 : int'(len);
        cs = addr + len;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a = addr + 8'(i);
            cs = cs + fdata[i];
            exp_w.push_back('{a, fdata[i]});
            rmem[a] = fdata[i];
        end
        if (corrupt) cs = cs ^ 8'h01;
        wq.delete();
        send_byte(8'hA5, gap);
        chk("sof_clears_err", {err, busy}, 2'b01);
        send_byte(addr, gap);
        send_byte(len, gap);
        for (int i = 0; i < n; i++) send_byte(fdata[i], gap);
        send_byte(cs, gap);
        chk("frame_done", done, !corrupt);
        chk("frame_err", err, corrupt);
        chk("frame_cpu_rst_n", cpu_rst_n, !corrupt);
        chk("frame_idle_flags", {busy, in_ready}, {1'b0, corrupt});
        if (wq.size() != exp_w.size()) mm++;
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
            if (wq[i].a !== exp_w[i].a || wq[i].d !== exp_w[i].d) mm++;
        chk("frame_writes", 32'(mm), 0);
        chk("frame_mem_image", 32'(mem_diff()), 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        total    = 0;
        bad      = 0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'hxx;

        tbl[0] = '{8'h10, 8'd3,  8'h01, 1'b0, 0, 1'b1, 1'b0};
        tbl[1] = '{8'hF0, 8'd32, 8'h33, 1'b0, 1, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'd1,  8'hA5, 1'b1, 0, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'd2,  8'h00, 1'b0, 2, 1'b1, 1'b0};
        tbl[4] = '{8'h40, 8'd16, 8'h7E, 1'b1, 1, 1'b0, 1'b1};

        @(negedge clk);
        reset_and_clear();

        // nominal load, then DONE must refuse further bytes
        load_nominal();
        send_frame(8'h00, 8'h05, 1'b0, 0);
        nom_img = dmem;
        wq.delete();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            chk("done_blocks_input", {in_ready, done, cpu_rst_n}, 3'b011);
        end
        in_valid = 1'b0;
        chk("done_no_writes", 32'(wq.size()), 0);

        // bad checksum, junk ignored in ERROR, then good resend
        reset_and_clear();
        load_nominal();
        send_frame(8'h00, 8'h05, 1'b1, 0);
        send_byte(8'h33, 0);
        chk("error_holds", {err, in_ready, done}, 3'b110);
        send_frame(8'h00, 8'h05, 1'b0, 0);

        // full-length frame wrapping past 0xFF
        reset_and_clear();
        fdata.delete();
        for (int i = 0; i < 256; i++) fdata.push_back(8'(i));
        send_frame(8'hFE, 8'h00, 1'b0, 0);

        // junk before SOF and valid toggling every other cycle
        reset_and_clear();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("junk_discarded", {busy, in_ready, 32'(wq.size())}, {1'b0, 1'b1, 32'd256});
        load_nominal();
        send_frame(8'h00, 8'h05, 1'b0, 1);
        begin
            int nd = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== nom_img[i]) nd++;
            chk("backpressure_image", 32'(nd), 0);
        end

        // reset after the second data byte abandons the frame and re-clears
        reset_and_clear();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        reset_and_clear();
        chk("reclear_image", 32'(mem_diff()), 0);
        load_nominal();
        send_frame(8'h00, 8'h05, 1'b0, 0);

        for (int k = 0; k < 5; k++) begin
            reset_and_clear();
            fdata.delete();
            for (int i = 0; i < int'(tbl[k].len); i++) fdata.push_back(tbl[k].seed + 8'(i * 3));
            send_frame(tbl[k].addr, tbl[k].len, tbl[k].corrupt, tbl[k].gap);
            chk("table_status", {done, err}, {tbl[k].exp_done, tbl[k].exp_err});
        end

        for (int r = 0; r < 6; r++) begin
            reset_and_clear();
            for (int f = 0; f < 4; f++) begin
                logic [7:0] a = 8'($urandom);
                logic [7:0] l = 8'($urandom_range(1, 48));
                bit         c = (f < 3) && ($urandom_range(0, 2) == 0);
                int         g = $urandom_range(0, 1);
                repeat ($urandom_range(0, 2)) begin
                    logic [7:0] j = 8'($urandom);
                    if (j == 8'hA5) j = 8'h5A;
                    send_byte(j, 0);
                end
                fdata.delete();
                for (int i = 0; i < int'(l); i++) fdata.push_back(8'($urandom));
                send_frame(a, l, c, g);
                if (!c) break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_boot_loader.md
Name: spm_boot_loader

Overview:
- Upstream program-load stage for the RISC_SPM core.
- Clears the core's 256x8 program memory through its write port.
- Receives one framed program image over a byte valid/ready stream and writes it into that memory.
- Holds the core in reset (RISC_SPM rst is active-low) until the image is loaded and its checksum passes; this replaces hierarchical memory preloading in benches and FPGA builds.

Parameters:
- ADDR_W, 8, memory address width; depth = 2**ADDR_W.
- DATA_W, 8, memory and stream byte width.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole memory after reset before accepting frames; 0 = skip the fill.
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid & in_ready at a rising edge.
- mem_we  out  1  memory write enable, one cycle per write.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- cpu_rst_n  out  1  drives RISC_SPM rst; 0 holds the core in reset.
- busy  out  1  clearing or frame in progress.
- done  out  1  image loaded and verified; sticky.
- err  out  1  last frame failed checksum; sticky until next SOF.

Behaviour:
- All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=1, done=0, err=0.
- Post-reset state: CLEAR if CLEAR_ON_RESET, else IDLE.
- Frame format: SOF_BYTE, ADDR, LEN, LEN data bytes, CSUM.
  - LEN=0 means 256 data bytes.
  - CSUM = (ADDR + LEN + all data bytes) mod 256.
- CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr steps 0..255, one address per cycle (256 write cycles), in_ready=0.
  - After the write to 255, go to IDLE.
- IDLE: in_ready=1, busy=0.
  - Accepted byte == SOF_BYTE: clear err, go to GET_ADDR, busy=1.
  - Any other byte is consumed and discarded.
- GET_ADDR: accept byte into the address counter and the checksum accumulator, go to GET_LEN.
- GET_LEN: accept byte into the remaining-count register (0 loads 256) and the checksum, go to DATA.
- DATA:
  - Each accepted byte: mem_we=1 with mem_addr=current address and mem_wdata=byte in the cycle after the handshake (1-cycle latency).
  - Address increments mod 256 (wrap 255->0); remaining-count decrements; byte added to the checksum.
  - After the last byte, go to CHECK.
  - in_valid low just stalls; no write, no state change.
- CHECK: accept one byte.
  - Byte == accumulator: go to DONE.
  - Otherwise: go to ERROR.
- DONE:
  - Registered one cycle after the CSUM handshake: done=1, cpu_rst_n=1.
  - in_ready=0, busy=0.
  - Held until rst; later stream bytes are not accepted.
- ERROR:
  - err=1, cpu_rst_n=0, busy=0, in_ready=1.
  - An accepted SOF_BYTE clears err and goes to GET_ADDR; other bytes are discarded.
  - Bytes already written are not rolled back.
- mem_we is never asserted outside CLEAR and DATA.
- in_ready is a registered function of state only; it never depends on in_valid combinationally.
- Reset in any state, including mid-CLEAR or mid-frame: immediate return to reset values.
  - A partial frame is abandoned.
  - With CLEAR_ON_RESET=1 the memory is fully re-cleared.
  - cpu_rst_n drops to 0 in the cycle after rst is sampled high.

Decomposition:
- Shared package spm_pkg holds:
  - state enum: CLEAR, IDLE, GET_ADDR, GET_LEN, DATA, CHECK, DONE, ERROR;
  - SOF constant 8'hA5;
  - memory depth constant 256.
- Single module; the checksum accumulator and counters are inline.
- No sub-module.

Test Plan:
- Reset clear: rst high 2 cycles then low, CLEAR_ON_RESET=1.
  - Expect exactly 256 consecutive mem_we pulses, addresses 0..255, data 0.
  - Then in_ready=1 and cpu_rst_n still 0.
- Nominal load: stream A5,00,05,00,50,03,40,80,CSUM=0x18.
  - Expect writes 0:00, 1:50, 2:03, 3:40, 4:80.
  - Expect done=1 and cpu_rst_n=1 one cycle after CSUM.
  - Afterwards the RISC_SPM core executes the program.
- Bad checksum: same frame with CSUM=0x19.
  - Expect err=1, done=0, cpu_rst_n=0.
  - Resend the correct frame; expect err=0, then done=1.
- Wrap and LEN=0: A5,FE,00, then 256 bytes of value i, then the correct CSUM.
  - Expect writes FE:00, FF:01, 00:02 ... FD:FF; done=1.
- Backpressure and junk: bytes 11,22 before SOF are discarded.
  - in_valid toggles every other cycle mid-frame; writes occur only on handshakes.
  - Final memory image is unchanged versus the nominal load.
- Reset mid-frame: assert rst after the 2nd data byte.
  - Expect all outputs at reset values the next cycle and a full re-clear.
  - A subsequent good frame loads correctly.
